// File: rtl/serial_word_receiver.sv
// serial_word_receiver: serial-to-parallel receiver with a one-entry valid/ready output buffer and sticky overrun.
// Define SERIAL_RX_PARITY_EN to expect a trailing even-parity bit per word and expose par_err.
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             dir,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             overrun,
  input  logic             ovr_clr,
`ifdef SERIAL_RX_PARITY_EN
  output logic             par_err,
`endif
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state;
  logic [WIDTH-1:0] sreg, shifted, word;
  logic [CW-1:0] count;
  logic dir_l, first, d_eff, done, last_data;
  always_comb begin
    first = ser_valid && (frame_start || state == IDLE);
    d_eff = first ? dir : dir_l;
    shifted = d_eff ? {sreg[WIDTH-2:0], ser_in} : {ser_in, sreg[WIDTH-1:1]};
    last_data = ser_valid && !first && state == SHIFT && count == CW'(WIDTH - 1);
`ifdef SERIAL_RX_PARITY_EN
    done = ser_valid && !frame_start && state == PARITY;
    word = sreg;
`else
    done = last_data;
    word = shifted;
`endif
  end
  assign busy = count != '0;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      sreg <= '0;
      count <= '0;
      dir_l <= 1'b0;
      par_out <= '0;
      par_valid <= 1'b0;
      overrun <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      if (first) begin
        sreg <= shifted;
        count <= CW'(1);
        dir_l <= dir;
        state <= SHIFT;
      end else if (frame_start) begin
        count <= '0;
        state <= IDLE;
      end else if (ser_valid && state == SHIFT) begin
        sreg <= shifted;
`ifdef SERIAL_RX_PARITY_EN
        count <= last_data ? CW'(WIDTH) : count + CW'(1);
        state <= last_data ? PARITY : SHIFT;
      end else if (ser_valid) begin
        count <= '0;
        state <= IDLE;
`else
        count <= last_data ? '0 : count + CW'(1);
        state <= last_data ? IDLE : SHIFT;
`endif
      end
      // A word completing while the buffer drains this same edge is still accepted
      if (done && (!par_valid || par_ready)) begin
        par_out <= word;
        par_valid <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        par_err <= ^sreg ^ ser_in;
`endif
      end else if (par_valid && par_ready) begin
        par_valid <= 1'b0;
      end
      if (done && par_valid && !par_ready) overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end
endmodule
